// File: rtl/micro1_io_buffer.sv
// micro1_io_buffer
//   Byte-wide I/O buffer between the MICRO-1 datapath and a host link.
//   Input FIFO:  host pushes (valid/ready), datapath pops via if_rd_en.
//   Output FIFO: datapath pushes via of_wr_en, host pops (valid/ready).
//   Both FIFOs are first-word-fall-through: the head byte is a combinational
//   read at the read pointer, forced to 8'h00 while the FIFO is empty.
//
// Ports
//   clk, rst                       single clock, synchronous active-high reset
//   host_in_data/valid/ready       host -> input FIFO handshake
//   if_dout, if_rd_en              input FIFO head and datapath pop strobe
//   if_empty, if_count             input FIFO status
//   of_din, of_wr_en, of_full      datapath -> output FIFO write side
//   host_out_data/valid/ready      output FIFO -> host handshake
//   if_underflow, of_overflow      sticky error flags, cleared only by rst
module micro1_io_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [7:0]            if_dout,
  input  logic                  if_rd_en,
  output logic                  if_empty,
  output logic [DEPTH_LOG2:0]   if_count,
  input  logic [7:0]            of_din,
  input  logic                  of_wr_en,
  output logic                  of_full,
  output logic [7:0]            host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  output logic                  if_underflow,
  output logic                  of_overflow
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Storage is deliberately not reset; only pointers, counts and flags are.
  logic [7:0] if_mem [DEPTH];
  logic [7:0] of_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] if_wp_q, if_wp_d, if_rp_q, if_rp_d;
  logic [DEPTH_LOG2-1:0] of_wp_q, of_wp_d, of_rp_q, of_rp_d;
  logic [DEPTH_LOG2:0]   if_cnt_q, if_cnt_d, of_cnt_q, of_cnt_d;
  logic                  if_uf_q, if_uf_d, of_ov_q, of_ov_d;

  logic if_full_w, of_empty_w;
  logic if_push, if_pop, of_push, of_pop;

  // Full/empty come from the registered counts only, so a pop never frees
  // space for a push in the same cycle.
  assign if_empty   = (if_cnt_q == '0);
  assign if_full_w  = (if_cnt_q == CNT_FULL);
  assign of_empty_w = (of_cnt_q == '0);
  assign of_full    = (of_cnt_q == CNT_FULL);

  assign host_in_ready  = !if_full_w;
  assign host_out_valid = !of_empty_w;
  assign if_count       = if_cnt_q;

  assign if_push = host_in_valid && !if_full_w;
  assign if_pop  = if_rd_en && !if_empty;
  assign of_push = of_wr_en && !of_full;
  assign of_pop  = host_out_ready && !of_empty_w;

  assign if_dout       = if_empty   ? 8'h00 : if_mem[if_rp_q];
  assign host_out_data = of_empty_w ? 8'h00 : of_mem[of_rp_q];

  assign if_underflow = if_uf_q;
  assign of_overflow  = of_ov_q;

  always_comb begin
    if_wp_d  = if_wp_q;
    if_rp_d  = if_rp_q;
    if_cnt_d = if_cnt_q;
    of_wp_d  = of_wp_q;
    of_rp_d  = of_rp_q;
    of_cnt_d = of_cnt_q;

    if (if_push) if_wp_d = if_wp_q + PTR_ONE;
    if (if_pop)  if_rp_d = if_rp_q + PTR_ONE;
    case ({if_push, if_pop})
      2'b10:   if_cnt_d = if_cnt_q + CNT_ONE;
      2'b01:   if_cnt_d = if_cnt_q - CNT_ONE;
      default: if_cnt_d = if_cnt_q;
    endcase

    if (of_push) of_wp_d = of_wp_q + PTR_ONE;
    if (of_pop)  of_rp_d = of_rp_q + PTR_ONE;
    case ({of_push, of_pop})
      2'b10:   of_cnt_d = of_cnt_q + CNT_ONE;
      2'b01:   of_cnt_d = of_cnt_q - CNT_ONE;
      default: of_cnt_d = of_cnt_q;
    endcase

    // An underflow still lets a same-cycle push through; an overflow is
    // judged on the registered full even if the host pops this cycle.
    if_uf_d = if_uf_q | (if_rd_en & if_empty);
    of_ov_d = of_ov_q | (of_wr_en & of_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_wp_q  <= '0;
      if_rp_q  <= '0;
      if_cnt_q <= '0;
      of_wp_q  <= '0;
      of_rp_q  <= '0;
      of_cnt_q <= '0;
      if_uf_q  <= 1'b0;
      of_ov_q  <= 1'b0;
    end else begin
      if_wp_q  <= if_wp_d;
      if_rp_q  <= if_rp_d;
      if_cnt_q <= if_cnt_d;
      of_wp_q  <= of_wp_d;
      of_rp_q  <= of_rp_d;
      of_cnt_q <= of_cnt_d;
      if_uf_q  <= if_uf_d;
      of_ov_q  <= of_ov_d;
    end
  end

  // Writes are suppressed during reset so a handshake in the reset cycle
  // leaves no trace at all.
  always_ff @(posedge clk) begin
    if (!rst && if_push) if_mem[if_wp_q] <= host_in_data;
    if (!rst && of_push) of_mem[of_wp_q] <= of_din;
  end

endmodule

// File: tb/tb_micro1_io_buffer.sv
module tb_micro1_io_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk;
  logic          rst;
  logic [7:0]    host_in_data;
  logic          host_in_valid;
  logic          host_in_ready;
  logic [7:0]    if_dout;
  logic          if_rd_en;
  logic          if_empty;
  logic [DL:0]   if_count;
  logic [7:0]    of_din;
  logic          of_wr_en;
  logic          of_full;
  logic [7:0]    host_out_data;
  logic          host_out_valid;
  logic          host_out_ready;
  logic          if_underflow;
  logic          of_overflow;

  micro1_io_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready),
    .if_dout(if_dout), .if_rd_en(if_rd_en), .if_empty(if_empty),
    .if_count(if_count),
    .of_din(of_din), .of_wr_en(of_wr_en), .of_full(of_full),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .if_underflow(if_underflow), .of_overflow(of_overflow)
  );

  // Clock starts high so the first event is a falling edge: the model sees
  // the reset before the first rising edge does.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each FIFO is just a queue of bytes in arrival order.
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  bit         m_uf = 0;
  bit         m_ov = 0;
  bit         model_live = 0;
  int         n_in_consumed = 0;
  int         n_out_consumed = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard on the falling edge: compare DUT against the model,
  // then apply the handshakes the coming rising edge will perform.
  always @(negedge clk) begin
    bit in_push, in_pop, out_push, out_pop;
    if (model_live) begin
      chk("host_in_ready", int'(host_in_ready), int'(in_q.size() < DEPTH));
      chk("if_empty", int'(if_empty), int'(in_q.size() == 0));
      chk("if_count", int'(if_count), in_q.size());
      chk("if_dout", int'(if_dout), (in_q.size() > 0) ? int'(in_q[0]) : 0);
      chk("of_full", int'(of_full), int'(out_q.size() == DEPTH));
      chk("host_out_valid", int'(host_out_valid), int'(out_q.size() > 0));
      chk("host_out_data", int'(host_out_data), (out_q.size() > 0) ? int'(out_q[0]) : 0);
      chk("if_underflow", int'(if_underflow), int'(m_uf));
      chk("of_overflow", int'(of_overflow), int'(m_ov));
    end
    if (rst) begin
      in_q.delete();
      out_q.delete();
      m_uf = 0;
      m_ov = 0;
      model_live = 1;
    end else if (model_live) begin
      in_push  = host_in_valid && (in_q.size() < DEPTH);
      in_pop   = if_rd_en && (in_q.size() > 0);
      out_push = of_wr_en && (out_q.size() < DEPTH);
      out_pop  = host_out_ready && (out_q.size() > 0);
      if (if_rd_en && in_q.size() == 0) m_uf = 1;
      if (of_wr_en && out_q.size() == DEPTH) m_ov = 1;
      if (in_pop)  begin void'(in_q.pop_front());  n_in_consumed++;  end
      if (out_pop) begin void'(out_q.pop_front()); n_out_consumed++; end
      if (in_push)  in_q.push_back(host_in_data);
      if (out_push) out_q.push_back(of_din);
    end
  end

  task automatic cyc(bit v, logic [7:0] d, bit rd, bit wr, logic [7:0] din, bit rdy);
    host_in_valid  = v;
    host_in_data   = d;
    if_rd_en       = rd;
    of_wr_en       = wr;
    of_din         = din;
    host_out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) cyc(0, 8'h00, 0, 0, 8'h00, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    host_in_valid = 1'b1;
    host_in_data = 8'hC3;
    if_rd_en = 1'b0;
    of_wr_en = 1'b1;
    of_din = 8'h3C;
    host_out_ready = 1'b0;

    // Reset with handshakes offered: nothing must be captured.
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (3) cyc(0, 8'h00, 0, 0, 8'h00, 0);

    // Input FWFT ordering.
    cyc(1, 8'h11, 0, 0, 8'h00, 0);
    cyc(1, 8'h22, 0, 0, 8'h00, 0);
    cyc(1, 8'h33, 0, 0, 8'h00, 0);
    repeat (3) cyc(0, 8'h00, 1, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);

    // Input full, rejected 17th offer, then pointer wrap.
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 8'h00, 0);
    cyc(1, 8'hFF, 0, 0, 8'h00, 0);
    repeat (4) cyc(0, 8'h00, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 8'h00, 0);
    repeat (DEPTH) cyc(0, 8'h00, 1, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);

    // Output overflow while the host pops in the same cycle.
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 0, 1, 8'h80 + 8'(i), 0);
    cyc(0, 8'h00, 0, 1, 8'hEE, 1);
    repeat (DEPTH) cyc(0, 8'h00, 0, 0, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);
    do_reset(1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);

    // Underflow with a simultaneous push.
    cyc(1, 8'h5A, 1, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);
    cyc(0, 8'h00, 1, 0, 8'h00, 0);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);
    do_reset(2);

    // Concurrent random streaming, protocol obeyed, one mid-stream reset.
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) do_reset(1);
      cyc(bit'($urandom_range(0, 1)), 8'($urandom),
          bit'($urandom_range(0, 1)) && (in_q.size() > 0),
          bit'($urandom_range(0, 1)) && (out_q.size() < DEPTH),
          8'($urandom), bit'($urandom_range(0, 1)));
    end
    repeat (2 * DEPTH) cyc(0, 8'h00, in_q.size() > 0, 0, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0);
    chk("stream_in_drained", int'(if_empty), 1);
    chk("stream_out_drained", int'(host_out_valid), 0);
    chk("stream_in_consumed_nonzero", int'(n_in_consumed > 1000), 1);
    chk("stream_out_consumed_nonzero", int'(n_out_consumed > 1000), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/micro1_io_buffer.md
# micro1_io_buffer

Byte-wide I/O buffer on the far side of the MICRO-1 datapath's `if_dout`/`of_din` ports. Holds an input FIFO that a host fills and the datapath drains, and an output FIFO that the datapath fills and the host drains. Sits between the processor core and the host link: a UART bridge, testbench driver, or debug port. Both FIFOs are first-word-fall-through, so the datapath's combinational `inbus` path sees the head byte without a read-latency cycle.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: log2 of each FIFO's depth; depth = 2^DEPTH_LOG2 entries, each 8 bits.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous reset, active-high.
- `host_in_data`  in  8  byte from host into the input FIFO.
- `host_in_valid`  in  1  host offers `host_in_data`.
- `host_in_ready`  out  1  input FIFO can accept; equals `!if_full`.
- `if_dout`  out  8  head of the input FIFO; 8'h00 when empty.
- `if_rd_en`  in  1  datapath consumes the head byte.
- `if_empty`  out  1  input FIFO holds no data.
- `if_count`  out  DEPTH_LOG2+1  input FIFO occupancy.
- `of_din`  in  8  byte from datapath into the output FIFO.
- `of_wr_en`  in  1  datapath writes `of_din`.
- `of_full`  out  1  output FIFO holds 2^DEPTH_LOG2 entries.
- `host_out_data`  out  8  head of the output FIFO; 8'h00 when empty.
- `host_out_valid`  out  1  equals `!of_empty`.
- `host_out_ready`  in  1  host accepts `host_out_data`.
- `if_underflow`  out  1  sticky: `if_rd_en` asserted while `if_empty`.
- `of_overflow`  out  1  sticky: `of_wr_en` asserted while `of_full`.

## Operation
- Each FIFO is a circular buffer with a write pointer and a read pointer (DEPTH_LOG2 bits each, natural wrap-around at 2^DEPTH_LOG2) and a count register (DEPTH_LOG2+1 bits).
- Full and empty are decoded from the count register only: full = count==2^DEPTH_LOG2, empty = count==0.

Input FIFO:
- Push occurs on `host_in_valid && host_in_ready`.
- Pop occurs on `if_rd_en && !if_empty`.
- Push and pop in the same cycle leave the count unchanged.
- A pop while empty is ignored and sets `if_underflow`. This holds even if a push occurs in the same cycle; the pushed byte is stored normally.

Output FIFO:
- Push occurs on `of_wr_en && !of_full`.
- Pop occurs on `host_out_valid && host_out_ready`.
- A write while full is dropped and sets `of_overflow`. This holds even if the host pops in the same cycle, because full is evaluated on the registered count.

Common rules:
- Head outputs are combinational reads of the storage at the read pointer, gated to 8'h00 when empty.
- Sticky flags clear only on `rst`.
- Storage contents are not reset; only pointers, counts and flags are.

## Timing
- Reset values:
  - `host_in_ready`=1, `if_dout`=8'h00, `if_empty`=1, `if_count`=0.
  - `of_full`=0, `host_out_data`=8'h00, `host_out_valid`=0.
  - `if_underflow`=0, `of_overflow`=0.
- Reset is sampled on `clk` rising edge. A reset asserted mid-transfer discards all buffered bytes. Any handshake in the reset cycle has no effect.
- Latency:
  - A byte pushed at edge N appears on `if_dout`/`host_out_data` and deasserts empty after edge N.
  - Pass-through from host to datapath is 1 cycle; from datapath to host is 1 cycle.
- After a pop at edge N, the next byte, or 8'h00 if the FIFO is now empty, is visible after edge N.
- `host_in_ready` and `of_full` update one cycle after the count changes. A pop never makes space usable in the same cycle.
- Sticky flags assert one cycle after the offending edge.
- Sustained throughput is one byte per cycle per direction when the producer and consumer are both active.

## Test plan
- **Reset defaults:** assert `rst` for 2 cycles with `host_in_valid`=1 and `of_wr_en`=1 -> all outputs hold their reset values, and counts stay 0 after release until a new handshake.
- **Input FWFT ordering:** host pushes 8'h11, 8'h22, 8'h33 on consecutive cycles, then `if_rd_en` held for 3 cycles -> `if_dout` reads 11, 22, 33; then `if_empty`=1 and `if_dout`=00; `if_count` goes 0,1,2,3,2,1,0.
- **Input full and wrap:** with DEPTH_LOG2=4, push 16 bytes 8'h00–8'h0F -> `host_in_ready`=0 and a 17th offer is not accepted. Pop 4, push 8'hA0–8'hA3 -> read-out order is 04…0F, then A0…A3, confirming pointer wrap.
- **Output overflow:** fill the output FIFO with 16 writes, then `of_wr_en` with 8'hEE while `host_out_ready`=1 in the same cycle -> 8'hEE is dropped, `of_overflow`=1, and the host receives the 16 original bytes only.
- **Underflow with simultaneous push:** empty input FIFO; in one cycle assert `if_rd_en` with `host_in_valid`/8'h5A -> `if_underflow`=1, `if_count`=1 and `if_dout`=8'h5A next cycle.
- **Concurrent streaming:** random valid/ready on both host ports plus random `if_rd_en`/`of_wr_en` for 10k cycles against a scoreboard -> no loss, duplication or reordering, and the flags stay 0 whenever the protocol is obeyed.
